// File: rtl/dither_pkg.sv
`default_nettype none
// ============================================================================
// dither_pkg: shared state, slot and neighbour-offset definitions. Rev 1.0
// ============================================================================
package dither_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    D_SEL  = 4'd2,
    D_RD   = 4'd3,
    D_WAIT = 4'd4,
    D_WR   = 4'd5,
    U_RD   = 4'd6,
    U_WAIT = 4'd7,
    U_OUT  = 4'd8,
    DONE   = 4'd9
  } seq_state_t;

  typedef logic [2:0] slot_t;

  localparam int c_ADJ_PIXELS = 4;
  localparam int c_NUM_SLOTS  = c_ADJ_PIXELS + 1;

  localparam slot_t c_SLOT_SELF = 3'd0;
  localparam slot_t c_SLOT_E    = 3'd1;
  localparam slot_t c_SLOT_SW   = 3'd2;
  localparam slot_t c_SLOT_S    = 3'd3;
  localparam slot_t c_SLOT_SE   = 3'd4;

  // Offsets of each slot relative to the pixel being dithered.
  localparam int c_DX [c_NUM_SLOTS] = '{0, 1, -1, 0, 1};
  localparam int c_DY [c_NUM_SLOTS] = '{0, 0,  1, 1, 1};

endpackage
`default_nettype wire

// File: rtl/neighbour_addr_gen.sv
`default_nettype none
// ============================================================================
// neighbour_addr_gen: picks the lowest remaining valid slot and its address. Rev 1.0
// ============================================================================
module neighbour_addr_gen
  import dither_pkg::*;
#(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_ADDR_WIDTH = 12,
  parameter int XW               = 6,
  parameter int YW               = 6
) (
  input  logic [XW-1:0]               i_x,
  input  logic [YW-1:0]               i_y,
  input  logic [c_NUM_SLOTS-1:0]      i_issued,
  output slot_t                       o_slot,
  output logic [IMAGE_ADDR_WIDTH-1:0] o_addr,
  output logic                        o_none
);

  logic [c_NUM_SLOTS-1:0] w_valid;
  logic [c_NUM_SLOTS-1:0] w_remain;

  always_comb begin
    w_valid              = '0;
    w_valid[c_SLOT_SELF] = 1'b1;
    w_valid[c_SLOT_E]    = (int'(i_x) < IMAGEX - 1);
    w_valid[c_SLOT_SW]   = (i_x != '0) && (int'(i_y) < IMAGEY - 1);
    w_valid[c_SLOT_S]    = (int'(i_y) < IMAGEY - 1);
    w_valid[c_SLOT_SE]   = (int'(i_x) < IMAGEX - 1) && (int'(i_y) < IMAGEY - 1);
    w_remain             = w_valid & ~i_issued;

    o_slot = c_SLOT_SELF;
    o_none = 1'b1;
    for (int s = c_NUM_SLOTS - 1; s >= 0; s--) begin
      if (w_remain[s]) begin
        o_slot = slot_t'(s);
        o_none = 1'b0;
      end
    end

    o_addr = IMAGE_ADDR_WIDTH'((int'(i_y) + c_DY[o_slot]) * IMAGEX + int'(i_x) + c_DX[o_slot]);
  end

endmodule
`default_nettype wire

// File: rtl/dither_frame_sequencer.sv
`default_nettype none
// ============================================================================
// dither_frame_sequencer: LOAD / DITHER / UNLOAD frame controller on RAM port A. Rev 1.0
// ============================================================================
module dither_frame_sequencer
  import dither_pkg::*;
#(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int ADJ_PIXELS       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        MCU_TX_RDY,
  input  logic [RGB_SIZE-1:0]         mcu_byte,
  input  logic [RGB_SIZE-1:0]         ram_q_a,
  input  logic [RGB_SIZE-1:0]         dp_q,
  input  logic                        out_ready,
  output logic [IMAGE_ADDR_WIDTH-1:0] addr_a,
  output logic [RGB_SIZE-1:0]         data_a,
  output logic                        wren_a,
  output logic [IMAGE_ADDR_WIDTH-1:0] png_idx,
  output logic                        dp_capture,
  output logic [2:0]                  dp_slot,
  output logic [RGB_SIZE-1:0]         out_data,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int c_XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int c_YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam logic [c_XW-1:0]             c_XMAX   = c_XW'(IMAGEX - 1);
  localparam logic [c_YW-1:0]             c_YMAX   = c_YW'(IMAGEY - 1);
  localparam logic [c_XW-1:0]             c_X_ONE  = c_XW'(1);
  localparam logic [c_YW-1:0]             c_Y_ONE  = c_YW'(1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] c_A_ONE  = IMAGE_ADDR_WIDTH'(1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] c_A_LAST = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [ADJ_PIXELS:0]         c_ISSUED_SELF = {{ADJ_PIXELS{1'b0}}, 1'b1};

  seq_state_t                  r_state;
  logic [c_XW-1:0]             r_x;
  logic [c_YW-1:0]             r_y;
  logic [ADJ_PIXELS:0]         r_issued;
  slot_t                       r_slot;
  logic [IMAGE_ADDR_WIDTH-1:0] r_pix_addr;
  logic [IMAGE_ADDR_WIDTH-1:0] r_u_idx;
  logic [IMAGE_ADDR_WIDTH-1:0] r_addr;
  logic [RGB_SIZE-1:0]         r_data;
  logic                        r_wren;
  logic [IMAGE_ADDR_WIDTH-1:0] r_png_idx;
  logic                        r_dp_capture;
  slot_t                       r_dp_slot;
  logic [RGB_SIZE-1:0]         r_out_data;
  logic                        r_out_valid;
  logic                        r_busy;
  logic                        r_done;

  slot_t                       w_gen_slot;
  logic [IMAGE_ADDR_WIDTH-1:0] w_gen_addr;
  logic                        w_gen_none;
  logic                        w_last_pixel;

  neighbour_addr_gen #(
    .IMAGEX           (IMAGEX),
    .IMAGEY           (IMAGEY),
    .IMAGE_ADDR_WIDTH (IMAGE_ADDR_WIDTH),
    .XW               (c_XW),
    .YW               (c_YW)
  ) u_neighbour_addr_gen (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_issued (r_issued),
    .o_slot   (w_gen_slot),
    .o_addr   (w_gen_addr),
    .o_none   (w_gen_none)
  );

  assign w_last_pixel = (r_x == c_XMAX) && (r_y == c_YMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_issued     <= '0;
      r_slot       <= c_SLOT_SELF;
      r_pix_addr   <= '0;
      r_u_idx      <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wren       <= 1'b0;
      r_png_idx    <= '0;
      r_dp_capture <= 1'b0;
      r_dp_slot    <= c_SLOT_SELF;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wren       <= 1'b0;
      r_dp_capture <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= LOAD;
            r_png_idx <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (MCU_TX_RDY) begin
            r_wren <= 1'b1;
            r_addr <= r_png_idx;
            r_data <= mcu_byte;
            if (r_png_idx == c_A_LAST) begin
              r_png_idx  <= '0;
              r_state    <= D_SEL;
              r_x        <= '0;
              r_y        <= '0;
              r_issued   <= '0;
              r_pix_addr <= '0;
            end else begin
              r_png_idx <= r_png_idx + c_A_ONE;
            end
          end
        end
        // Slot selection folds into the write cycle so skipped slots cost nothing.
        D_SEL, D_WR: begin
          if (!w_gen_none) begin
            r_state              <= D_RD;
            r_addr               <= w_gen_addr;
            r_slot               <= w_gen_slot;
            r_issued[w_gen_slot] <= 1'b1;
          end else if (w_last_pixel) begin
            r_state <= U_RD;
            r_addr  <= '0;
            r_u_idx <= '0;
          end else begin
            if (r_x == c_XMAX) begin
              r_x <= '0;
              r_y <= r_y + c_Y_ONE;
            end else begin
              r_x <= r_x + c_X_ONE;
            end
            r_pix_addr <= r_pix_addr + c_A_ONE;
            r_addr     <= r_pix_addr + c_A_ONE;
            r_slot     <= c_SLOT_SELF;
            r_issued   <= c_ISSUED_SELF;
            r_state    <= D_RD;
          end
        end
        D_RD: begin
          r_state      <= D_WAIT;
          r_dp_capture <= 1'b1;
          r_dp_slot    <= r_slot;
        end
        D_WAIT: begin
          r_state <= D_WR;
          r_wren  <= 1'b1;
          r_data  <= dp_q;
        end
        U_RD: r_state <= U_WAIT;
        U_WAIT: begin
          r_state     <= U_OUT;
          r_out_valid <= 1'b1;
          r_out_data  <= ram_q_a;
        end
        U_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_u_idx == c_A_LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_u_idx <= r_u_idx + c_A_ONE;
              r_addr  <= r_u_idx + c_A_ONE;
              r_state <= U_RD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign addr_a     = r_addr;
  assign data_a     = r_data;
  assign wren_a     = r_wren;
  assign png_idx    = r_png_idx;
  assign dp_capture = r_dp_capture;
  assign dp_slot    = r_dp_slot;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dither_frame_sequencer.sv
`default_nettype none
// tb_dither_frame_sequencer: 4x4 frames against a behavioural RAM and a frame-level
// model of expected port-A writes and unload stream.
module tb_dither_frame_sequencer;

  localparam int c_W = 4;
  localparam int c_H = 4;
  localparam int c_N = c_W * c_H;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] slot;
    logic       dith;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst, start, mcu_rdy, out_ready;
  logic [7:0] mcu_byte, ram_q_a, dp_q;
  logic [3:0] addr_a, png_idx;
  logic [7:0] data_a, out_data;
  logic       wren_a, dp_capture, out_valid, busy, done;
  logic [2:0] dp_slot;

  logic [7:0] mem     [c_N];
  logic [7:0] frame_b [c_N];
  logic [7:0] exp_img [c_N];
  wr_t        exp_q[$];
  wr_t        cur_e;
  int         dith_log [64];
  int         n_vec = 0, n_err = 0, cyc = 0, n_out = 0, n_dith = 0, last_wr_cyc = 0;
  bit         chk_en = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  dither_frame_sequencer #(.IMAGEX(c_W), .IMAGEY(c_H), .RGB_SIZE(8), .ADJ_PIXELS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .MCU_TX_RDY(mcu_rdy), .mcu_byte(mcu_byte),
    .ram_q_a(ram_q_a), .dp_q(dp_q), .out_ready(out_ready), .addr_a(addr_a), .data_a(data_a),
    .wren_a(wren_a), .png_idx(png_idx), .dp_capture(dp_capture), .dp_slot(dp_slot),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read, and a +1 datapath.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wren_a) mem[addr_a] <= data_a;
    ram_q_a <= mem[addr_a];
  end
  assign dp_q = ram_q_a + 8'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: load writes in order, then for each raster pixel every valid
  // neighbour in slot order is rewritten as its current value plus one.
  task automatic build_model();
    int dx [5] = '{0, 1, -1, 0, 1};
    int dy [5] = '{0, 0, 1, 1, 1};
    wr_t e;
    bit  ok;
    int  a;
    exp_q.delete();
    for (int i = 0; i < c_N; i++) begin
      exp_img[i] = frame_b[i];
      e.addr = 4'(i); e.data = frame_b[i]; e.slot = 3'd0; e.dith = 1'b0;
      exp_q.push_back(e);
    end
    for (int y = 0; y < c_H; y++)
      for (int x = 0; x < c_W; x++)
        for (int s = 0; s < 5; s++) begin
          ok = 1'b1;
          if ((s == 1 || s == 4) && x >= c_W - 1) ok = 1'b0;
          if (s == 2 && x == 0) ok = 1'b0;
          if (s >= 2 && y >= c_H - 1) ok = 1'b0;
          if (ok) begin
            a = (y + dy[s]) * c_W + x + dx[s];
            exp_img[a] = exp_img[a] + 8'd1;
            e.addr = 4'(a); e.data = exp_img[a]; e.slot = 3'(s); e.dith = 1'b1;
            exp_q.push_back(e);
          end
        end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (wren_a) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_write: addr %0d data 0x%0h, no write expected", addr_a, data_a);
        end else begin
          cur_e = exp_q.pop_front();
          chk("wr_addr", 32'(addr_a), 32'(cur_e.addr));
          chk("wr_data", 32'(data_a), 32'(cur_e.data));
          if (cur_e.dith) begin
            chk("wr_spacing", cyc - last_wr_cyc, 3);
            if (n_dith < 64) dith_log[n_dith] = int'(addr_a);
            n_dith++;
          end else begin
            chk("png_idx_load", 32'(png_idx), (32'(cur_e.addr) + 1) % 16);
          end
          last_wr_cyc = cyc;
        end
      end
      if (dp_capture) begin
        if (exp_q.size() == 0 || !exp_q[0].dith) begin
          n_vec++; n_err++;
          $display("FAIL spurious_capture: dp_slot %0d with no dither write pending", dp_slot);
        end else begin
          chk("dp_slot", 32'(dp_slot), 32'(exp_q[0].slot));
        end
      end
      if (prev_stall) begin
        chk("valid_hold", 32'(out_valid), 1);
        chk("data_hold", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (n_out < c_N) chk("out_data", 32'(out_data), 32'(exp_img[n_out]));
        else begin
          n_vec++; n_err++;
          $display("FAIL extra_transfer: data 0x%0h after %0d transfers", out_data, n_out);
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic run_frame(input int mode);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pin_idx  [9] = '{14, 15, 16, 21, 22, 23, 24, 25, 57};
    int pin_addr [9] = '{3, 6, 7, 5, 6, 8, 9, 10, 15};
    int i;
    for (int k = 0; k < c_N; k++) frame_b[k] = (mode == 1) ? 8'(8'h10 + k) : 8'($urandom);
    build_model();
    n_out = 0;
    n_dith = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    chk("done_after_start", 32'(done), 0);
    chk("png_idx_after_start", 32'(png_idx), 0);
    tick();
    i = 0;
    while (i < c_N) begin
      if (mode != 1 && $urandom_range(0, 2) == 0) mcu_rdy = 1'b0;
      else begin
        mcu_rdy = 1'b1;
        mcu_byte = frame_b[i];
        i++;
      end
      tick();
    end
    mcu_rdy = 1'b0;
    for (int c = 0; c < 3000 && n_out < c_N; c++) begin
      out_ready = (mode == 1) ? pat[c % 4] : 1'($urandom_range(0, 1));
      if (out_valid || n_out > 0) begin
        start    = 1'b0;
        mcu_rdy  = (mode == 1) ? (c % 5 == 2) : ($urandom_range(0, 3) == 0);
        mcu_byte = 8'($urandom);
      end else begin
        mcu_rdy  = (mode != 1) && ($urandom_range(0, 3) == 0);
        start    = (mode == 1) ? (c % 37 == 5) : ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    start = 1'b0;
    mcu_rdy = 1'b0;
    out_ready = 1'b0;
    chk("unload_count", n_out, c_N);
    repeat (2) tick();
    @(negedge clk);
    chk("done_at_end", 32'(done), 1);
    chk("busy_at_end", 32'(busy), 0);
    chk("valid_at_end", 32'(out_valid), 0);
    chk("writes_pending", exp_q.size(), 0);
    chk("dither_write_count", n_dith, 58);
    for (int k = 0; k < 9; k++) chk("pinned_dither_addr", dith_log[pin_idx[k]], pin_addr[k]);
    for (int k = 0; k < c_N; k++) chk("ram_final", 32'(mem[k]), 32'(exp_img[k]));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mcu_rdy = 1'b0; mcu_byte = 8'd0; out_ready = 1'b0;
    for (int k = 0; k < c_N; k++) mem[k] = 8'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wren", 32'(wren_a), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_png_idx", 32'(png_idx), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_dp_capture", 32'(dp_capture), 0);
    rst = 1'b0;
    tick();

    // Abort a load after five strobes.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mcu_rdy = 1'b1;
      mcu_byte = 8'(8'hA0 + k);
      tick();
    end
    mcu_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_wren", 32'(wren_a), 0);
    chk("abort_png_idx", 32'(png_idx), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ram_kept", 32'(mem[4]), 32'h0A4);
    tick();

    chk_en = 1'b1;
    run_frame(1);
    run_frame(2);
    run_frame(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
